// File: rtl/alu_reg_operand_collector.sv
// ALU Reg-Reg operand collector: accepts one issued op per cycle, gathers operands A/B
// from WB forwarding or PRF read responses, and hands complete ops to execute via valid/ready.
module alu_reg_operand_collector #(
    parameter int PRF_BANK_COUNT     = 4,
    parameter int LOG_PRF_BANK_COUNT = 2,
    parameter int LOG_PR_COUNT       = 7,
    parameter int LOG_ROB_ENTRIES    = 7,
    parameter int DATA_W             = 32
) (
    input  logic                                         CLK,
    input  logic                                         nRST,

    input  logic                                         issue_valid,
    input  logic [3:0]                                   issue_op,
    input  logic                                         issue_A_forward,
    input  logic [LOG_PRF_BANK_COUNT-1:0]                issue_A_bank,
    input  logic                                         issue_B_forward,
    input  logic [LOG_PRF_BANK_COUNT-1:0]                issue_B_bank,
    input  logic [LOG_PR_COUNT-1:0]                      issue_dest_PR,
    input  logic [LOG_ROB_ENTRIES-1:0]                   issue_ROB_index,
    output logic                                         pipeline_ready,

    input  logic                                         A_reg_read_ack,
    input  logic                                         A_reg_read_port,
    input  logic                                         B_reg_read_ack,
    input  logic                                         B_reg_read_port,
    input  logic [PRF_BANK_COUNT-1:0][1:0][DATA_W-1:0]   reg_read_data_by_bank_by_port,
    input  logic [PRF_BANK_COUNT-1:0][DATA_W-1:0]        forward_data_by_bank,

    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [3:0]                                   out_op,
    output logic [DATA_W-1:0]                            out_A,
    output logic [DATA_W-1:0]                            out_B,
    output logic [LOG_PR_COUNT-1:0]                      out_dest_PR,
    output logic [LOG_ROB_ENTRIES-1:0]                   out_ROB_index
);

    typedef struct packed {
        logic [3:0]                    op;
        logic                          a_forward;
        logic [LOG_PRF_BANK_COUNT-1:0] a_bank;
        logic                          b_forward;
        logic [LOG_PRF_BANK_COUNT-1:0] b_bank;
        logic [LOG_PR_COUNT-1:0]       dest_pr;
        logic [LOG_ROB_ENTRIES-1:0]    rob_index;
    } oc_fields_t;

    // Operand-collect stage
    logic              oc_valid;
    logic              oc_first;
    oc_fields_t        oc;
    logic              a_saved;
    logic              b_saved;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;

    // Per-cycle operand arrival
    logic [DATA_W-1:0] a_incoming;
    logic [DATA_W-1:0] b_incoming;
    logic              a_capture;
    logic              b_capture;
    logic              a_avail;
    logic              b_avail;
    logic [DATA_W-1:0] a_value;
    logic [DATA_W-1:0] b_value;

    logic              launch;
    logic              accept;

    // A forwarded operand is only on the WB bus in the first OC cycle, and it takes
    // priority over any PRF ack for the same operand.
    assign a_incoming = oc.a_forward ? forward_data_by_bank[oc.a_bank]
                                     : reg_read_data_by_bank_by_port[oc.a_bank][A_reg_read_port];
    assign b_incoming = oc.b_forward ? forward_data_by_bank[oc.b_bank]
                                     : reg_read_data_by_bank_by_port[oc.b_bank][B_reg_read_port];

    assign a_capture = oc_valid && !a_saved && (oc.a_forward ? oc_first : A_reg_read_ack);
    assign b_capture = oc_valid && !b_saved && (oc.b_forward ? oc_first : B_reg_read_ack);

    assign a_avail = a_saved || a_capture;
    assign b_avail = b_saved || b_capture;

    assign a_value = a_saved ? a_data : a_incoming;
    assign b_value = b_saved ? b_data : b_incoming;

    assign launch = oc_valid && a_avail && b_avail && (!out_valid || out_ready);

    // NOTE: combinational ready so a launching op frees OC for an issue in the same cycle;
    // gated by nRST so nothing is accepted while reset is asserted.
    assign pipeline_ready = nRST && (!oc_valid || launch);
    assign accept         = issue_valid && pipeline_ready;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            oc_valid <= 1'b0;
            oc_first <= 1'b0;
            a_saved  <= 1'b0;
            b_saved  <= 1'b0;
        end else if (accept) begin
            oc_valid <= 1'b1;
            oc_first <= 1'b1;
            a_saved  <= 1'b0;
            b_saved  <= 1'b0;
        end else begin
            oc_first <= 1'b0;
            if (launch) begin
                oc_valid <= 1'b0;
            end else begin
                if (a_capture) a_saved <= 1'b1;
                if (b_capture) b_saved <= 1'b1;
            end
        end
    end

    // NOTE: payload registers carry no reset; they are only observed when the matching
    // valid/saved flag is set, and those flags are reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            oc.op        <= issue_op;
            oc.a_forward <= issue_A_forward;
            oc.a_bank    <= issue_A_bank;
            oc.b_forward <= issue_B_forward;
            oc.b_bank    <= issue_B_bank;
            oc.dest_pr   <= issue_dest_PR;
            oc.rob_index <= issue_ROB_index;
        end
        if (a_capture) a_data <= a_incoming;
        if (b_capture) b_data <= b_incoming;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            out_valid     <= 1'b0;
            out_op        <= '0;
            out_A         <= '0;
            out_B         <= '0;
            out_dest_PR   <= '0;
            out_ROB_index <= '0;
        end else if (launch) begin
            out_valid     <= 1'b1;
            out_op        <= oc.op;
            out_A         <= a_value;
            out_B         <= b_value;
            out_dest_PR   <= oc.dest_pr;
            out_ROB_index <= oc.rob_index;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

    // A PRF ack for an operand that is already saved is an upstream protocol error.
    a_double_ack: assert property (@(posedge CLK) disable iff (!nRST)
        !(oc_valid && !oc.a_forward && a_saved && A_reg_read_ack))
        else $error("operand A acked after it was already saved");

    b_double_ack: assert property (@(posedge CLK) disable iff (!nRST)
        !(oc_valid && !oc.b_forward && b_saved && B_reg_read_ack))
        else $error("operand B acked after it was already saved");

endmodule

// File: tb/tb_alu_reg_operand_collector.sv
// Directed bench for alu_reg_operand_collector: table of single-op vectors plus
// hand-written back-to-back, stall and mid-operation reset sequences.
module tb_alu_reg_operand_collector;

    logic               CLK;
    logic               nRST;
    logic               issue_valid;
    logic [3:0]         issue_op;
    logic               issue_A_forward;
    logic [1:0]         issue_A_bank;
    logic               issue_B_forward;
    logic [1:0]         issue_B_bank;
    logic [6:0]         issue_dest_PR;
    logic [6:0]         issue_ROB_index;
    logic               pipeline_ready;
    logic               A_reg_read_ack;
    logic               A_reg_read_port;
    logic               B_reg_read_ack;
    logic               B_reg_read_port;
    logic [3:0][1:0][31:0] reg_read_data_by_bank_by_port;
    logic [3:0][31:0]   forward_data_by_bank;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         out_op;
    logic [31:0]        out_A;
    logic [31:0]        out_B;
    logic [6:0]         out_dest_PR;
    logic [6:0]         out_ROB_index;

    alu_reg_operand_collector dut (
        .CLK                           (CLK),
        .nRST                          (nRST),
        .issue_valid                   (issue_valid),
        .issue_op                      (issue_op),
        .issue_A_forward               (issue_A_forward),
        .issue_A_bank                  (issue_A_bank),
        .issue_B_forward               (issue_B_forward),
        .issue_B_bank                  (issue_B_bank),
        .issue_dest_PR                 (issue_dest_PR),
        .issue_ROB_index               (issue_ROB_index),
        .pipeline_ready                (pipeline_ready),
        .A_reg_read_ack                (A_reg_read_ack),
        .A_reg_read_port               (A_reg_read_port),
        .B_reg_read_ack                (B_reg_read_ack),
        .B_reg_read_port               (B_reg_read_port),
        .reg_read_data_by_bank_by_port (reg_read_data_by_bank_by_port),
        .forward_data_by_bank          (forward_data_by_bank),
        .out_valid                     (out_valid),
        .out_ready                     (out_ready),
        .out_op                        (out_op),
        .out_A                         (out_A),
        .out_B                         (out_B),
        .out_dest_PR                   (out_dest_PR),
        .out_ROB_index                 (out_ROB_index)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [31:0] fwd_good [4] = '{32'h1111_0000, 32'h5555_0002, 32'hAAAA_0001, 32'h3333_0003};

    typedef struct packed {
        logic [3:0]  op;
        logic        a_fwd;
        logic [1:0]  a_bank;
        logic        a_port;
        logic [3:0]  a_dly;    // cycle after issue carrying an A ack (0 = none)
        logic        b_fwd;
        logic [1:0]  b_bank;
        logic        b_port;
        logic [3:0]  b_dly;
        logic [6:0]  rob;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [3:0]  exp_lat;  // cycles from issue to out_valid
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive_fwd(input bit good);
        for (int b = 0; b < 4; b++)
            forward_data_by_bank[b] = good ? fwd_good[b] : (32'hDEAD_0000 | 32'(b));
    endtask

    task automatic drive_rd(input bit good);
        for (int b = 0; b < 4; b++)
            for (int p = 0; p < 2; p++)
                reg_read_data_by_bank_by_port[b][p] = good ? (32'hC0DE_0000 | 32'(b * 16 + p))
                                                           : (32'hBAD0_0000 | 32'(b * 16 + p));
    endtask

    task automatic idle();
        issue_valid    = 1'b0;
        A_reg_read_ack = 1'b0;
        B_reg_read_ack = 1'b0;
        drive_fwd(1'b0);
        drive_rd(1'b0);
    endtask

    task automatic issue(input logic a_fwd, input logic [1:0] a_bank,
                         input logic b_fwd, input logic [1:0] b_bank, input logic [6:0] rob);
        issue_valid     = 1'b1;
        issue_op        = rob[3:0];
        issue_A_forward = a_fwd;
        issue_A_bank    = a_bank;
        issue_B_forward = b_fwd;
        issue_B_bank    = b_bank;
        issue_dest_PR   = rob + 7'd1;
        issue_ROB_index = rob;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        lat = int'(v.exp_lat);
        @(negedge CLK);
        idle();
        issue_valid     = 1'b1;
        issue_op        = v.op;
        issue_A_forward = v.a_fwd;
        issue_A_bank    = v.a_bank;
        issue_B_forward = v.b_fwd;
        issue_B_bank    = v.b_bank;
        issue_dest_PR   = v.rob + 7'd1;
        issue_ROB_index = v.rob;
        #1 check($sformatf("v%0d_ready_at_issue", idx), pipeline_ready, 1);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge CLK);
            issue_valid     = 1'b0;
            A_reg_read_ack  = (k == int'(v.a_dly));
            A_reg_read_port = v.a_port;
            B_reg_read_ack  = (k == int'(v.b_dly));
            B_reg_read_port = v.b_port;
            drive_fwd(k == 1);
            drive_rd(A_reg_read_ack || B_reg_read_ack);
            #1;
            if (k < lat)
                check($sformatf("v%0d_ready_k%0d", idx, k), pipeline_ready, (k >= lat - 1));
            check($sformatf("v%0d_valid_k%0d", idx, k), out_valid, (k == lat));
            if (k == lat) begin
                check($sformatf("v%0d_A", idx), out_A, v.exp_a);
                check($sformatf("v%0d_B", idx), out_B, v.exp_b);
                check($sformatf("v%0d_op", idx), out_op, v.op);
                check($sformatf("v%0d_dest", idx), out_dest_PR, v.rob + 7'd1);
                check($sformatf("v%0d_rob", idx), out_ROB_index, v.rob);
            end
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{op:4'd1, a_fwd:1'b1, a_bank:2'd2, a_port:1'b0, a_dly:4'd0,
                    b_fwd:1'b1, b_bank:2'd1, b_port:1'b0, b_dly:4'd0, rob:7'd1,
                    exp_a:32'hAAAA_0001, exp_b:32'h5555_0002, exp_lat:4'd2};
        vecs[1] = '{op:4'd2, a_fwd:1'b0, a_bank:2'd3, a_port:1'b0, a_dly:4'd1,
                    b_fwd:1'b0, b_bank:2'd0, b_port:1'b1, b_dly:4'd3, rob:7'd2,
                    exp_a:32'hC0DE_0030, exp_b:32'hC0DE_0001, exp_lat:4'd4};
        vecs[2] = '{op:4'd3, a_fwd:1'b1, a_bank:2'd0, a_port:1'b1, a_dly:4'd1,
                    b_fwd:1'b0, b_bank:2'd2, b_port:1'b0, b_dly:4'd1, rob:7'd3,
                    exp_a:32'h1111_0000, exp_b:32'hC0DE_0020, exp_lat:4'd2};
        vecs[3] = '{op:4'd4, a_fwd:1'b0, a_bank:2'd1, a_port:1'b1, a_dly:4'd2,
                    b_fwd:1'b1, b_bank:2'd3, b_port:1'b0, b_dly:4'd0, rob:7'd4,
                    exp_a:32'hC0DE_0011, exp_b:32'h3333_0003, exp_lat:4'd3};
        vecs[4] = '{op:4'd5, a_fwd:1'b1, a_bank:2'd3, a_port:1'b0, a_dly:4'd2,
                    b_fwd:1'b0, b_bank:2'd1, b_port:1'b0, b_dly:4'd3, rob:7'd5,
                    exp_a:32'h3333_0003, exp_b:32'hC0DE_0010, exp_lat:4'd4};
        vecs[5] = '{op:4'd6, a_fwd:1'b0, a_bank:2'd2, a_port:1'b1, a_dly:4'd2,
                    b_fwd:1'b0, b_bank:2'd2, b_port:1'b0, b_dly:4'd2, rob:7'd6,
                    exp_a:32'hC0DE_0021, exp_b:32'hC0DE_0020, exp_lat:4'd3};

        nRST            = 1'b0;
        out_ready       = 1'b1;
        issue_op        = '0;
        issue_A_forward = 1'b0;
        issue_A_bank    = '0;
        issue_B_forward = 1'b0;
        issue_B_bank    = '0;
        issue_dest_PR   = '0;
        issue_ROB_index = '0;
        A_reg_read_port = 1'b0;
        B_reg_read_port = 1'b0;
        idle();

        // Reset state
        repeat (2) @(negedge CLK);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_ready_low", pipeline_ready, 0);
        check("rst_out_A", out_A, 0);
        check("rst_out_B", out_B, 0);
        check("rst_out_rob", out_ROB_index, 0);
        @(negedge CLK);
        nRST = 1'b1;
        #1 check("rst_ready_after", pipeline_ready, 1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Back-to-back: four forwarded ops on consecutive cycles
        for (int c = 0; c <= 6; c++) begin
            @(negedge CLK);
            if (c < 4) issue(1'b1, 2'(c), 1'b1, 2'(3 - c), 7'(10 + c));
            else       issue_valid = 1'b0;
            drive_fwd(1'b1);
            #1;
            if (c < 4) check($sformatf("b2b_ready_c%0d", c), pipeline_ready, 1);
            if (c >= 2 && c <= 5) begin
                check($sformatf("b2b_valid_c%0d", c), out_valid, 1);
                check($sformatf("b2b_rob_c%0d", c), out_ROB_index, 7'(10 + c - 2));
                check($sformatf("b2b_A_c%0d", c), out_A, fwd_good[c - 2]);
                check($sformatf("b2b_B_c%0d", c), out_B, fwd_good[3 - (c - 2)]);
            end
            if (c == 6) check("b2b_valid_end", out_valid, 0);
        end
        idle();

        // Execute stalls 3 cycles while OC also holds a complete op
        for (int c = 0; c <= 8; c++) begin
            @(negedge CLK);
            case (c)
                0: issue(1'b1, 2'd0, 1'b1, 2'd1, 7'd20);
                1: issue(1'b1, 2'd2, 1'b1, 2'd3, 7'd21);
                2: issue(1'b1, 2'd3, 1'b1, 2'd0, 7'd22);
                6: issue_valid = 1'b0;
                default: ;
            endcase
            out_ready = !(c >= 2 && c <= 4);
            drive_fwd(c == 1 || c == 2 || c == 6);
            #1;
            if (c == 1) check("stall_ready_c1", pipeline_ready, 1);
            if (c >= 2 && c <= 5) begin
                check($sformatf("stall_ready_c%0d", c), pipeline_ready, (c == 5));
                check($sformatf("stall_valid_c%0d", c), out_valid, 1);
                check($sformatf("stall_rob_c%0d", c), out_ROB_index, 20);
                check($sformatf("stall_A_c%0d", c), out_A, 32'h1111_0000);
                check($sformatf("stall_B_c%0d", c), out_B, 32'h5555_0002);
            end
            if (c == 6) begin
                check("stall_rob_c6", out_ROB_index, 21);
                check("stall_A_c6", out_A, 32'hAAAA_0001);
                check("stall_B_c6", out_B, 32'h3333_0003);
            end
            if (c == 7) begin
                check("stall_valid_c7", out_valid, 1);
                check("stall_rob_c7", out_ROB_index, 22);
                check("stall_A_c7", out_A, 32'h3333_0003);
            end
            if (c == 8) check("stall_valid_end", out_valid, 0);
        end
        out_ready = 1'b1;
        idle();

        // Reset while A is saved and B is still pending
        @(negedge CLK);
        issue(1'b0, 2'd1, 1'b0, 2'd2, 7'd30);
        @(negedge CLK);
        issue_valid     = 1'b0;
        A_reg_read_ack  = 1'b1;
        A_reg_read_port = 1'b0;
        drive_rd(1'b1);
        #1 check("midrst_ready_partial", pipeline_ready, 0);
        @(negedge CLK);
        A_reg_read_ack = 1'b0;
        drive_rd(1'b0);
        nRST = 1'b0;
        #1 check("midrst_ready_in_reset", pipeline_ready, 0);
        @(negedge CLK);
        nRST            = 1'b1;
        B_reg_read_ack  = 1'b1;
        B_reg_read_port = 1'b1;
        drive_rd(1'b1);
        #1;
        check("midrst_valid_c3", out_valid, 0);
        check("midrst_ready_c3", pipeline_ready, 1);
        @(negedge CLK);
        idle();
        #1 check("midrst_valid_c4", out_valid, 0);
        @(negedge CLK);
        #1 check("midrst_valid_c5", out_valid, 0);

        run_vec(vecs[0], 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
